// File: rtl/puf_race_ctrl.sv
// -----------------------------------------------------------------------------
// puf_race_ctrl
//
// Runs the race between the two post-mux edge counters (A and B) of the
// delay-based PUF. For every challenge in a run it clears both counters, enables
// them, waits for the first `finished`, and records the winner as one response
// bit (A first = 1). After RESP_BITS consecutive challenges the assembled word
// is published on `response` with a one-cycle `done` pulse.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high reset (also aborts a run)
//   start         begin a run; only looked at while idle
//   challenge_in  base challenge, latched when a start is accepted
//   fin_a, fin_b  `finished` flags from counters A and B
//   cnt_reset     clear to both counters
//   cnt_enable    enable to both counters
//   cnt_challenge mux select for the bit in progress (base + bit index, wraps)
//   busy          run in progress
//   done          one-cycle pulse when a run completes
//   response      last completed response word (bit 0 = first challenge)
//   tie_seen      sticky for the run: a bit finished on both counters at once
//   timeout_err   sticky for the run: a bit saw no finish before the timeout
//
// Every output is decoded from registers only, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module puf_race_ctrl #(
  parameter int N          = 23,
  parameter int RESP_BITS  = 8,
  parameter int CHAL_W     = 8,
  parameter int CLR_CYCLES = 2,
  parameter int TO_W       = N + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    challenge_in,
  input  logic                 fin_a,
  input  logic                 fin_b,
  output logic                 cnt_reset,
  output logic                 cnt_enable,
  output logic [CHAL_W-1:0]    cnt_challenge,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 tie_seen,
  output logic                 timeout_err
);

  localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(RESP_BITS - 1);
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [TO_W-1:0]  TIMER_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [TO_W-1:0]       timer_q, timer_d;
  logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic [CHAL_W-1:0]     chal_q, chal_d;
  logic [RESP_BITS-1:0]  shadow_q, shadow_d;
  logic [RESP_BITS-1:0]  response_q, response_d;
  logic                  tie_q, tie_d;
  logic                  to_q, to_d;
  logic                  fa_cap_q, fa_cap_d;
  logic                  fb_cap_q, fb_cap_d;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    timer_d    = timer_q;
    clr_cnt_d  = clr_cnt_q;
    chal_d     = chal_q;
    shadow_d   = shadow_q;
    response_d = response_q;
    tie_d      = tie_q;
    to_d       = to_q;
    fa_cap_d   = fa_cap_q;
    fb_cap_d   = fb_cap_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d    = challenge_in;
          bit_idx_d = '0;
          shadow_d  = '0;
          tie_d     = 1'b0;
          to_d      = 1'b0;
          clr_cnt_d = '0;
          state_d   = S_CLR;
        end
      end

      S_CLR: begin
        // Holding the timer at zero here means RUN always starts from zero.
        timer_d = '0;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        timer_d = timer_q + 1'b1;
        // Capture every cycle; the values from the exit cycle are the ones
        // left in the capture flops when DECIDE looks at them.
        fa_cap_d = fin_a;
        fb_cap_d = fin_b;
        // The timeout fires in the cycle the timer reaches its maximum, so
        // RUN lasts at most 2^TO_W-1 cycles. A finish in that same cycle is
        // still captured as a finish.
        if (fin_a || fin_b || (timer_d == TIMER_MAX)) begin
          state_d = S_DECIDE;
        end
      end

      S_DECIDE: begin
        shadow_d[bit_idx_q] = fa_cap_q & ~fb_cap_q;
        if (fa_cap_q && fb_cap_q) begin
          tie_d = 1'b1;
        end
        if (!fa_cap_q && !fb_cap_q) begin
          to_d = 1'b1;
        end
        if (bit_idx_q == LAST_BIT) begin
          state_d = S_DONE;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          clr_cnt_d = '0;
          state_d   = S_CLR;
        end
      end

      S_DONE: begin
        response_d = shadow_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= '0;
      timer_q    <= '0;
      clr_cnt_q  <= '0;
      chal_q     <= '0;
      shadow_q   <= '0;
      response_q <= '0;
      tie_q      <= 1'b0;
      to_q       <= 1'b0;
      fa_cap_q   <= 1'b0;
      fb_cap_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
      clr_cnt_q  <= clr_cnt_d;
      chal_q     <= chal_d;
      shadow_q   <= shadow_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      to_q       <= to_d;
      fa_cap_q   <= fa_cap_d;
      fb_cap_q   <= fb_cap_d;
    end
  end

  // Moore output decode
  assign cnt_reset     = (state_q == S_IDLE) || (state_q == S_CLR) || (state_q == S_DONE);
  assign cnt_enable    = (state_q == S_RUN);
  assign busy          = (state_q == S_CLR) || (state_q == S_RUN) || (state_q == S_DECIDE);
  assign done          = (state_q == S_DONE);
  assign cnt_challenge = chal_q + CHAL_W'(bit_idx_q);
  assign response      = response_q;
  assign tie_seen      = tie_q;
  assign timeout_err   = to_q;

endmodule

// File: tb/tb_puf_race_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_race_ctrl
//
// Two instances: an 8-bit controller and a 1-bit controller (N=6, so the
// timeout is 127 RUN cycles). `sel` routes the shared stimulus to one of them
// and picks which outputs are observed. Each run is described by a per-bit
// plan (winner kind and the RUN cycle on which the finish appears); the
// expected cycle-by-cycle behaviour and final word come from that plan alone.
// -----------------------------------------------------------------------------
module tb_puf_race_ctrl;

  localparam int CLR_N   = 2;
  localparam int TO_LEN  = 127;  // 2^7 - 1 RUN cycles before the timeout
  localparam int K_A     = 0;
  localparam int K_B     = 1;
  localparam int K_TIE   = 2;
  localparam int K_NONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] challenge_in;
  logic       fin_a, fin_b;
  logic       sel;

  // 8-bit instance
  logic       s8, fa8, fb8;
  logic       r8_reset, r8_en, r8_busy, r8_done, r8_tie, r8_to;
  logic [7:0] r8_chal, r8_resp;
  // 1-bit instance
  logic       s1, fa1, fb1;
  logic       r1_reset, r1_en, r1_busy, r1_done, r1_tie, r1_to;
  logic [7:0] r1_chal;
  logic [0:0] r1_resp;

  assign s8  = start & ~sel;
  assign fa8 = fin_a & ~sel;
  assign fb8 = fin_b & ~sel;
  assign s1  = start & sel;
  assign fa1 = fin_a & sel;
  assign fb1 = fin_b & sel;

  puf_race_ctrl #(.N(6), .RESP_BITS(8), .CHAL_W(8), .CLR_CYCLES(CLR_N)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .challenge_in(challenge_in),
    .fin_a(fa8), .fin_b(fb8), .cnt_reset(r8_reset), .cnt_enable(r8_en),
    .cnt_challenge(r8_chal), .busy(r8_busy), .done(r8_done),
    .response(r8_resp), .tie_seen(r8_tie), .timeout_err(r8_to)
  );

  puf_race_ctrl #(.N(6), .RESP_BITS(1), .CHAL_W(8), .CLR_CYCLES(CLR_N)) u_dut1 (
    .clk(clk), .reset(reset), .start(s1), .challenge_in(challenge_in),
    .fin_a(fa1), .fin_b(fb1), .cnt_reset(r1_reset), .cnt_enable(r1_en),
    .cnt_challenge(r1_chal), .busy(r1_busy), .done(r1_done),
    .response(r1_resp), .tie_seen(r1_tie), .timeout_err(r1_to)
  );

  logic       o_reset, o_en, o_busy, o_done, o_tie, o_to;
  logic [7:0] o_chal, o_resp;
  assign o_reset = sel ? r1_reset : r8_reset;
  assign o_en    = sel ? r1_en    : r8_en;
  assign o_busy  = sel ? r1_busy  : r8_busy;
  assign o_done  = sel ? r1_done  : r8_done;
  assign o_tie   = sel ? r1_tie   : r8_tie;
  assign o_to    = sel ? r1_to    : r8_to;
  assign o_chal  = sel ? r1_chal  : r8_chal;
  assign o_resp  = sel ? {7'd0, r1_resp} : r8_resp;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int plan_kind [8];
  int plan_when [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cnt_reset"}, 32'(o_reset), 32'd1);
    check({tag, "_cnt_enable"}, 32'(o_en), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_response"}, 32'(o_resp), 32'd0);
    check({tag, "_tie"}, 32'(o_tie), 32'd0);
    check({tag, "_timeout"}, 32'(o_to), 32'd0);
    check({tag, "_chal"}, 32'(o_chal), 32'd0);
  endtask

  // Fill the plan with random winners; allow_odd enables ties and timeouts.
  task automatic random_plan(input bit allow_odd);
    for (int i = 0; i < 8; i++) begin
      int r;
      r = allow_odd ? $urandom_range(0, 9) : $urandom_range(0, 7);
      plan_kind[i] = (r < 4) ? K_A : (r < 8) ? K_B : (r == 8) ? K_TIE : K_NONE;
      plan_when[i] = $urandom_range(1, 12);
    end
  endtask

  // Drive one run and check it cycle by cycle. Called at a negedge with the
  // selected controller idle (launch=1) or already in its first CLR cycle
  // (launch=0). abort_bit>=0 asserts reset on the 2nd RUN cycle of that bit.
  task automatic run_word(input logic [7:0] base, input bit launch, input bit mid_start,
                          input bit hold_end, input logic [7:0] next_base, input int abort_bit);
    int         nb;
    int         len;
    logic [7:0] exp_resp;
    logic [7:0] exp_chal;
    bit         exp_tie, exp_to;

    nb       = sel ? 1 : 8;
    exp_resp = '0;
    exp_tie  = 1'b0;
    exp_to   = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (plan_kind[i] == K_A)    exp_resp[i] = 1'b1;
      if (plan_kind[i] == K_TIE)  exp_tie = 1'b1;
      if (plan_kind[i] == K_NONE) exp_to = 1'b1;
    end

    if (launch) begin
      start = 1'b1;
      challenge_in = base;
      @(negedge clk);
    end
    start = 1'b0;
    challenge_in = $urandom;  // must not matter once latched

    for (int i = 0; i < nb; i++) begin
      exp_chal = base + 8'(i);
      for (int c = 0; c < CLR_N; c++) begin
        check("clr_cnt_reset", 32'(o_reset), 32'd1);
        check("clr_enable", 32'(o_en), 32'd0);
        check("clr_busy", 32'(o_busy), 32'd1);
        check("clr_chal", 32'(o_chal), 32'(exp_chal));
        if (i == 0 && c == 0) begin
          check("start_clears_tie", 32'(o_tie), 32'd0);
          check("start_clears_timeout", 32'(o_to), 32'd0);
        end
        fin_a = 1'($urandom);  // ignored outside RUN
        fin_b = 1'($urandom);
        @(negedge clk);
      end
      len = (plan_kind[i] == K_NONE) ? TO_LEN : plan_when[i];
      for (int k = 1; k <= len; k++) begin
        check("run_enable", 32'(o_en), 32'd1);
        check("run_cnt_reset", 32'(o_reset), 32'd0);
        if (k == 1) check("run_chal", 32'(o_chal), 32'(exp_chal));
        if (i == abort_bit && k == 2) begin
          reset = 1'b1;
          fin_a = 1'b0;
          fin_b = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          check_reset_state("abort");
          $display("run sel=%0d base=%02h aborted by reset in bit %0d", sel, base, i);
          return;
        end
        fin_a = (k == len) && (plan_kind[i] == K_A || plan_kind[i] == K_TIE);
        fin_b = (k == len) && (plan_kind[i] == K_B || plan_kind[i] == K_TIE);
        start = mid_start && (i == 0) && (k == 1);
        @(negedge clk);
      end
      start = 1'b0;
      check("decide_enable", 32'(o_en), 32'd0);
      check("decide_cnt_reset", 32'(o_reset), 32'd0);
      check("decide_busy", 32'(o_busy), 32'd1);
      check("decide_done", 32'(o_done), 32'd0);
      check("decide_chal", 32'(o_chal), 32'(exp_chal));
      fin_a = 1'($urandom);  // DECIDE uses the exit-cycle values
      fin_b = 1'($urandom);
      @(negedge clk);
    end
    fin_a = 1'b0;
    fin_b = 1'b0;

    check("done_pulse", 32'(o_done), 32'd1);
    check("done_busy", 32'(o_busy), 32'd0);
    check("done_cnt_reset", 32'(o_reset), 32'd1);
    check("done_enable", 32'(o_en), 32'd0);
    check("done_tie", 32'(o_tie), 32'(exp_tie));
    check("done_timeout", 32'(o_to), 32'(exp_to));
    if (hold_end) begin
      start = 1'b1;
      challenge_in = next_base;
    end
    @(negedge clk);
    check("idle_done", 32'(o_done), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("response", 32'(o_resp), 32'(exp_resp));
    check("idle_tie", 32'(o_tie), 32'(exp_tie));
    check("idle_timeout", 32'(o_to), 32'(exp_to));
    $display("run sel=%0d base=%02h resp=%02h tie=%0d timeout=%0d (expected %02h/%0d/%0d)",
             sel, base, o_resp, o_tie, o_to, exp_resp, exp_tie, exp_to);
    @(negedge clk);
    if (hold_end) begin
      start = 1'b0;  // accepted on the first IDLE cycle, now in CLR
    end else begin
      check("stay_idle", 32'(o_busy), 32'd0);
      check("single_done", 32'(o_done), 32'd0);
      check("response_held", 32'(o_resp), 32'(exp_resp));
    end
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1;
    start = 1'b0;
    fin_a = 1'b0;
    fin_b = 1'b0;
    sel = 1'b0;
    challenge_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_state("rst8");
    sel = 1'b1;
    check_reset_state("rst1");

    // Single bit, A wins on the 5th RUN cycle
    plan_kind[0] = K_A;
    plan_when[0] = 5;
    run_word(8'h05, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    sel = 1'b0;
    @(negedge clk);

    // Eight bits A,B,B,A,A,B,A,B starting at 0xFE (challenge wraps)
    random_plan(1'b0);
    plan_kind[0] = K_A; plan_kind[1] = K_B; plan_kind[2] = K_B; plan_kind[3] = K_A;
    plan_kind[4] = K_A; plan_kind[5] = K_B; plan_kind[6] = K_A; plan_kind[7] = K_B;
    run_word(8'hFE, 1'b1, 1'b0, 1'b0, 8'h00, -1);

    // Tie on bit 0, timeout on bit 1
    random_plan(1'b0);
    plan_kind[0] = K_TIE;
    plan_when[0] = 3;
    plan_kind[1] = K_NONE;
    run_word(8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, -1);

    // Finishes on the very cycle the timer hits its maximum
    random_plan(1'b0);
    plan_kind[2] = K_A;
    plan_when[2] = TO_LEN;
    plan_kind[5] = K_B;
    plan_when[5] = TO_LEN;
    run_word(8'h80, 1'b1, 1'b0, 1'b0, 8'h00, -1);

    // Random runs, some with a start pulse during RUN
    for (int r = 0; r < 6; r++) begin
      random_plan(1'b1);
      b = 8'($urandom);
      run_word(b, 1'b1, 1'(r & 1), 1'b0, 8'h00, -1);
    end

    // Reset during RUN of bit 3, then a normal run
    random_plan(1'b0);
    plan_when[3] = 10;
    run_word(8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 3);
    @(negedge clk);
    random_plan(1'b1);
    run_word(8'h22, 1'b1, 1'b0, 1'b0, 8'h00, -1);

    // Start held across DONE->IDLE launches the next run immediately
    random_plan(1'b0);
    run_word(8'h40, 1'b1, 1'b0, 1'b1, 8'hF9, -1);
    random_plan(1'b1);
    run_word(8'hF9, 1'b0, 1'b0, 1'b0, 8'h00, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_race_ctrl.md
Name: puf_race_ctrl

Overview:
- Initiator/consumer for a pair of post-mux edge counters (A and B) in the delay-based PUF.
- Per challenge, clears both counters, enables them, waits for the first `finished`, and records the response bit (A first = 1).
- Repeats for RESP_BITS consecutive challenges and presents the response word to the serial layer with a start/done handshake.
- Sits between the serial command front-end and the two counter instances.

Parameters:
- N, 23, counter width. Used only to size the timeout; bench uses N=6.
- RESP_BITS, 8, response bits per run.
- CHAL_W, 8, challenge (mux select) width.
- CLR_CYCLES, 2, cycles `cnt_reset` is held per bit (≥1).
- TO_W, N+1, timeout timer width. Timeout fires when the timer reaches 2^TO_W-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run. Sampled only in IDLE.
- challenge_in  input  CHAL_W  base challenge, latched on an accepted start.
- fin_a  input  1  `finished` from counter A.
- fin_b  input  1  `finished` from counter B.
- cnt_reset  output  1  clear to both counters.
- cnt_enable  output  1  enable to both counters.
- cnt_challenge  output  CHAL_W  mux select for the current bit.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse: run complete.
- response  output  RESP_BITS  last completed response word.
- tie_seen  output  1  sticky per run: ≥1 bit resolved as a tie.
- timeout_err  output  1  sticky per run: ≥1 bit timed out.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-run):
  - state=IDLE, bit_idx=0, timer=0.
  - response=0, tie_seen=0, timeout_err=0, done=0, busy=0.
  - cnt_reset=1, cnt_enable=0, cnt_challenge=0.
  - Any partial response is discarded.
- States: IDLE, CLR, RUN, DECIDE, DONE. Outputs are decoded from the state register only (Moore); no combinational path from inputs to outputs.
- Output decode by state:
  - cnt_reset=1 in IDLE, CLR, DONE; 0 in RUN, DECIDE.
  - cnt_enable=1 in RUN only.
  - busy=1 in CLR, RUN, DECIDE.
  - done=1 in DONE only.
- IDLE:
  - start=1 → latch challenge_in into chal_q.
  - Clear bit_idx, shadow response, tie_seen, timeout_err.
  - Go to CLR.
  - start while not in IDLE is ignored.
- CLR:
  - Lasts exactly CLR_CYCLES cycles, then RUN.
  - Timer cleared on entry to RUN.
- cnt_challenge = chal_q + bit_idx, modulo 2^CHAL_W (wraps silently). Valid from CLR through DECIDE.
- RUN:
  - Timer increments each cycle.
  - Exit to DECIDE on the first cycle where fin_a|fin_b=1, or when timer = 2^TO_W-1.
  - Finish takes priority over timeout in the same cycle.
- DECIDE (1 cycle), uses the fin_a/fin_b values sampled on the exit cycle. Bit value:
  - fin_a & !fin_b → 1.
  - !fin_a & fin_b → 0.
  - both → 0, set tie_seen.
  - neither (timeout) → 0, set timeout_err.
- DECIDE write and next state:
  - Shadow[bit_idx] ← bit value. Bit 0 is the result of the first challenge.
  - If bit_idx = RESP_BITS-1 → DONE; else bit_idx+1 and → CLR.
- DONE (1 cycle):
  - response ← shadow, then → IDLE.
  - response, tie_seen, timeout_err hold until the next accepted start. tie_seen and timeout_err clear at that start; response holds until the next DONE.
- Latency per bit: CLR_CYCLES + (RUN cycles, ≥1) + 1.
  - Start accepted at edge t → CLR at t+1 → RUN at t+1+CLR_CYCLES.
  - done one cycle after the final DECIDE.
- fin_a/fin_b asserted during CLR or IDLE are ignored. Only RUN samples them.

Test Plan:
- Reset then idle 10 cycles:
  - cnt_reset=1, cnt_enable=0, busy=0, done=0, response=0.
- Single bit, A wins:
  - RESP_BITS=1, CLR_CYCLES=2, start with challenge_in=0x05.
  - Bench raises fin_a on the 5th RUN cycle.
  - Expect CLR for 2 cycles, cnt_enable for 5 cycles, cnt_challenge=0x05, then DECIDE, then done pulse.
  - response=1, tie_seen=0.
- Eight bits, winner pattern A,B,B,A,A,B,A,B:
  - response=8'b01011001.
  - cnt_challenge steps 0xFE,0xFF,0x00,…,0x05 when challenge_in=0xFE (wrap).
- Tie and timeout:
  - Bit 0: fin_a and fin_b raised in the same cycle → bit 0=0, tie_seen=1.
  - Bit 1: N=6, TO_W=7, no finish → RUN lasts 127 cycles, bit 1=0, timeout_err=1.
  - Finish raised on the same cycle the timer hits 127 → treated as a finish, timeout_err unchanged.
- Reset mid-run:
  - Assert reset during RUN of bit 3 → next cycle IDLE, all outputs at reset values.
  - A new start completes normally.
- Start during busy:
  - Pulse start in RUN → no effect; exactly one done pulse.
  - Start held high across DONE→IDLE → a new run begins the cycle after return to IDLE.
